// File: rtl/spatial_encoder.sv
// Spatial encoder: binds im/projm folds per channel, bundles each modality by
// per-bit majority, then fuses GSR/ECG/EEG into one fused-HV fold.
`ifndef GSR_NUM_CHANNEL
`define GSR_NUM_CHANNEL 3
`endif
`ifndef ECG_NUM_CHANNEL
`define ECG_NUM_CHANNEL 3
`endif
`ifndef EEG_NUM_CHANNEL
`define EEG_NUM_CHANNEL 5
`endif

module spatial_encoder #(
  parameter int FOLD_WIDTH      = 2000,
  parameter int NUM_FOLDS       = 1,
  parameter int NUM_FOLDS_WIDTH = 1,
  parameter int GSR_CH          = `GSR_NUM_CHANNEL,
  parameter int ECG_CH          = `ECG_NUM_CHANNEL,
  parameter int EEG_CH          = `EEG_NUM_CHANNEL,
  parameter int COUNT_WIDTH     = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [FOLD_WIDTH-1:0]      im_in,
  input  logic [FOLD_WIDTH-1:0]      projm_in,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [FOLD_WIDTH-1:0]      dout,
  output logic [NUM_FOLDS_WIDTH-1:0] dout_fold,
  output logic                       dout_last,
  output logic [1:0]                 state_dbg
);

  // Handshake: a beat/fold transfers on the rising edge where valid && ready;
  // valid may not depend on ready, and held outputs stay stable until taken.

  typedef enum logic [1:0] {ACC_GSR, ACC_ECG, ACC_EEG, OUT} state_t;

  localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  state_t                     state, state_nxt;
  logic                       run;
  logic [COUNT_WIDTH-1:0]     beat_cnt;
  logic [COUNT_WIDTH-1:0]     cnt [FOLD_WIDTH];
  logic [FOLD_WIDTH-1:0]      gsr_hv, ecg_hv;
  logic [NUM_FOLDS_WIDTH-1:0] fold_idx;

  logic [COUNT_WIDTH-1:0]     n_cur;
  logic                       accept, is_sep;
  logic [FOLD_WIDTH-1:0]      bound, thr, fused;

  assign state_dbg  = state;
  assign dout_valid = (state == OUT);
  assign din_ready  = run && (state != OUT);
  assign dout_last  = dout_valid && (dout_fold == LAST_FOLD);
  assign accept     = din_valid && din_ready;
  assign is_sep     = (beat_cnt == n_cur);
  assign bound      = im_in ^ projm_in;
  assign fused      = (gsr_hv & ecg_hv) | (gsr_hv & thr) | (ecg_hv & thr);

  always_comb begin
    n_cur = COUNT_WIDTH'(GSR_CH);
    case (state)
      ACC_ECG: n_cur = COUNT_WIDTH'(ECG_CH);
      ACC_EEG: n_cur = COUNT_WIDTH'(EEG_CH);
      default: n_cur = COUNT_WIDTH'(GSR_CH);
    endcase
  end

  // Strict majority: ties on an even channel count resolve to 0.
  always_comb begin
    thr = '0;
    for (int i = 0; i < FOLD_WIDTH; i++) begin
      thr[i] = (cnt[i] > (n_cur >> 1));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC_GSR: if (accept && is_sep) state_nxt = ACC_ECG;
      ACC_ECG: if (accept && is_sep) state_nxt = ACC_EEG;
      ACC_EEG: if (accept && is_sep) state_nxt = OUT;
      OUT:     if (dout_ready)       state_nxt = ACC_GSR;
      default: state_nxt = ACC_GSR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACC_GSR;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      for (int i = 0; i < FOLD_WIDTH; i++) cnt[i] <= '0;
    end else if (accept) begin
      if (is_sep) begin
        beat_cnt <= '0;
        for (int i = 0; i < FOLD_WIDTH; i++) cnt[i] <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        for (int i = 0; i < FOLD_WIDTH; i++) cnt[i] <= cnt[i] + COUNT_WIDTH'(bound[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gsr_hv    <= '0;
      ecg_hv    <= '0;
      dout      <= '0;
      dout_fold <= '0;
      fold_idx  <= '0;
    end else begin
      if (accept && is_sep) begin
        if (state == ACC_GSR) gsr_hv <= thr;
        if (state == ACC_ECG) ecg_hv <= thr;
        if (state == ACC_EEG) begin
          dout      <= fused;
          dout_fold <= fold_idx;
        end
      end
      if (dout_valid && dout_ready) begin
        fold_idx <= (fold_idx == LAST_FOLD) ? '0 : fold_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spatial_encoder.sv
// Bench for spatial_encoder: two instances (single-fold 3/3/5 and two-fold 3/2/3),
// table-driven folds with a scoreboard queue plus backpressure and reset sequences.
module tb_spatial_encoder;

  localparam int W = 8;

  typedef logic [4:0][7:0] beat5_t;
  typedef struct packed {
    beat5_t   g;
    beat5_t   e;
    beat5_t   x;
    logic [7:0] exp_dout;
    logic     exp_fold;
    logic     exp_last;
  } fold_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_s        [2];
  logic         din_valid_s  [2];
  logic         din_ready_s  [2];
  logic [W-1:0] im_s         [2];
  logic [W-1:0] pm_s         [2];
  logic         dout_valid_s [2];
  logic         dout_ready_s [2];
  logic [W-1:0] dout_s       [2];
  logic         dout_fold_s  [2];
  logic         dout_last_s  [2];
  logic [1:0]   state_dbg_s  [2];

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_qa[$];
  logic [9:0] exp_qb[$];

  spatial_encoder #(.FOLD_WIDTH(W), .NUM_FOLDS(1), .NUM_FOLDS_WIDTH(1),
                    .GSR_CH(3), .ECG_CH(3), .EEG_CH(5), .COUNT_WIDTH(7)) dut_a (
    .clk(clk), .rst(rst_s[0]), .din_valid(din_valid_s[0]), .din_ready(din_ready_s[0]),
    .im_in(im_s[0]), .projm_in(pm_s[0]), .dout_valid(dout_valid_s[0]),
    .dout_ready(dout_ready_s[0]), .dout(dout_s[0]), .dout_fold(dout_fold_s[0]),
    .dout_last(dout_last_s[0]), .state_dbg(state_dbg_s[0]));

  spatial_encoder #(.FOLD_WIDTH(W), .NUM_FOLDS(2), .NUM_FOLDS_WIDTH(1),
                    .GSR_CH(3), .ECG_CH(2), .EEG_CH(3), .COUNT_WIDTH(7)) dut_b (
    .clk(clk), .rst(rst_s[1]), .din_valid(din_valid_s[1]), .din_ready(din_ready_s[1]),
    .im_in(im_s[1]), .projm_in(pm_s[1]), .dout_valid(dout_valid_s[1]),
    .dout_ready(dout_ready_s[1]), .dout(dout_s[1]), .dout_fold(dout_fold_s[1]),
    .dout_last(dout_last_s[1]), .state_dbg(state_dbg_s[1]));

  function automatic int n_ch(input int sel, input int grp);
    int a [3] = '{3, 3, 5};
    int b [3] = '{3, 2, 3};
    return (sel == 0) ? a[grp] : b[grp];
  endfunction

  function automatic beat5_t pk(input logic [7:0] a, b, c, d, e);
    beat5_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
    return r;
  endfunction

  function automatic fold_vec_t mk(input beat5_t g, e, x, input logic [7:0] d,
                                   input logic f, l);
    fold_vec_t v;
    v.g = g; v.e = e; v.x = x; v.exp_dout = d; v.exp_fold = f; v.exp_last = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_check(input int sel);
    check("rst_din_ready",  32'(din_ready_s[sel]),  0);
    check("rst_dout_valid", 32'(dout_valid_s[sel]), 0);
    check("rst_dout",       32'(dout_s[sel]),       0);
    check("rst_dout_fold",  32'(dout_fold_s[sel]),  0);
    check("rst_dout_last",  32'(dout_last_s[sel]),  0);
    check("rst_state",      32'(state_dbg_s[sel]),  0);
  endtask

  // Drives one bound vector as a random im/projm pair; returns #1 after acceptance.
  task automatic beat(input int sel, input logic [7:0] b);
    int t;
    logic [7:0] mask;
    mask = 8'($urandom_range(0, 255));
    im_s[sel] = b ^ mask;
    pm_s[sel] = mask;
    din_valid_s[sel] = 1'b1;
    t = 0;
    while (!din_ready_s[sel] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: din_ready stayed 0, required 1 (inst %0d)", sel);
    end
    @(posedge clk);
    #1;
    din_valid_s[sel] = 1'b0;
  endtask

  task automatic send_groups(input int sel, input fold_vec_t v, input int eeg_beats);
    for (int c = 0; c < n_ch(sel, 0); c++) beat(sel, v.g[c]);
    beat(sel, 8'($urandom));
    for (int c = 0; c < n_ch(sel, 1); c++) beat(sel, v.e[c]);
    beat(sel, 8'($urandom));
    for (int c = 0; c < eeg_beats; c++) beat(sel, v.x[c]);
  endtask

  task automatic send_fold(input int sel, input fold_vec_t v);
    send_groups(sel, v, n_ch(sel, 2));
    check("pre_sep_dout_valid", 32'(dout_valid_s[sel]), 0);
    if (sel == 0) exp_qa.push_back({v.exp_fold, v.exp_last, v.exp_dout});
    else          exp_qb.push_back({v.exp_fold, v.exp_last, v.exp_dout});
    beat(sel, 8'($urandom));
    check("latency_dout_valid", 32'(dout_valid_s[sel]), 1);
    check("out_din_ready",      32'(din_ready_s[sel]),  0);
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst_s[s] && dout_valid_s[s] && dout_ready_s[s]) begin
        logic [9:0] e;
        if ((s == 0 && exp_qa.size() == 0) || (s == 1 && exp_qb.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: inst %0d emitted dout=%0h, required none", s, dout_s[s]);
        end else begin
          e = (s == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
          check("dout",      32'(dout_s[s]),      32'(e[7:0]));
          check("dout_fold", 32'(dout_fold_s[s]), 32'(e[9]));
          check("dout_last", 32'(dout_last_s[s]), 32'(e[8]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  fold_vec_t va [5];
  fold_vec_t vb [3];

  initial begin
    va[0] = mk(pk(8'hFF, 8'hFF, 8'hFF, 0, 0), pk(8'hFF, 8'hFF, 8'hFF, 0, 0),
               pk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'hFF, 1'b0, 1'b1);
    va[1] = mk(pk(8'h0F, 8'h0F, 8'hF0, 0, 0), pk(8'hF0, 8'hF0, 8'hF0, 0, 0),
               pk(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C), 8'h3C, 1'b0, 1'b1);
    va[2] = mk(pk(8'hAA, 8'hAA, 8'h00, 0, 0), pk(8'h55, 8'h55, 8'h55, 0, 0),
               pk(8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00), 8'hFF, 1'b0, 1'b1);
    va[3] = mk(pk(8'h00, 8'h00, 8'h00, 0, 0), pk(8'h81, 8'h81, 8'h00, 0, 0),
               pk(8'h81, 8'h81, 8'h00, 8'h00, 8'h00), 8'h00, 1'b0, 1'b1);
    va[4] = mk(pk(8'h12, 8'h34, 8'h56, 0, 0), pk(8'hFF, 8'h00, 8'h00, 0, 0),
               pk(8'h0F, 8'h0F, 8'h0F, 8'hF0, 8'hF0), 8'h06, 1'b0, 1'b1);
    vb[0] = mk(pk(8'h01, 8'h01, 8'h01, 0, 0), pk(8'h01, 8'h00, 0, 0, 0),
               pk(8'h00, 8'h00, 8'h00, 0, 0), 8'h00, 1'b0, 1'b0);
    vb[1] = mk(pk(8'h01, 8'h01, 8'h01, 0, 0), pk(8'h01, 8'h01, 0, 0, 0),
               pk(8'h00, 8'h00, 8'h00, 0, 0), 8'h01, 1'b1, 1'b1);
    vb[2] = mk(pk(8'hFF, 8'hFF, 8'hFF, 0, 0), pk(8'hFF, 8'hFF, 0, 0, 0),
               pk(8'hFF, 8'hFF, 8'hFF, 0, 0), 8'hFF, 1'b0, 1'b0);

    for (int s = 0; s < 2; s++) begin
      rst_s[s] = 1'b1; din_valid_s[s] = 1'b0; dout_ready_s[s] = 1'b1;
      im_s[s] = '0; pm_s[s] = '0;
    end
    #1;
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    #2;
    reset_check(0);
    reset_check(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    check("ready_before_edge", 32'(din_ready_s[0]), 0);
    @(posedge clk);
    #1;
    check("ready_after_reset_a", 32'(din_ready_s[0]), 1);
    check("ready_after_reset_b", 32'(din_ready_s[1]), 1);

    for (int i = 0; i < 5; i++) send_fold(0, va[i]);
    @(posedge clk); #1;

    // Backpressure: result held for 10 cycles while an upstream beat is offered.
    dout_ready_s[0] = 1'b0;
    send_fold(0, va[1]);
    im_s[0] = 8'hFF; pm_s[0] = 8'h00; din_valid_s[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_dout_valid", 32'(dout_valid_s[0]), 1);
      check("bp_dout",       32'(dout_s[0]),       32'h3C);
      check("bp_dout_fold",  32'(dout_fold_s[0]),  0);
      check("bp_din_ready",  32'(din_ready_s[0]),  0);
      check("bp_state",      32'(state_dbg_s[0]),  3);
    end
    @(posedge clk); #1;
    dout_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    din_valid_s[0] = 1'b0;
    check("bp_release_valid", 32'(dout_valid_s[0]), 0);
    check("bp_release_ready", 32'(din_ready_s[0]),  1);
    send_fold(0, va[0]);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) send_fold(1, vb[i]);
    @(posedge clk); #1;

    // Reset after two EEG beats of a fold on the two-fold instance (index is 1).
    send_groups(1, vb[2], 2);
    rst_s[1] = 1'b0;
    #1;
    reset_check(1);
    @(negedge clk);
    rst_s[1] = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midreset", 32'(din_ready_s[1]), 1);
    send_fold(1, vb[2]);

    repeat (5) @(posedge clk);
    #1;
    check("queue_a_drained", 32'(exp_qa.size()), 0);
    check("queue_b_drained", 32'(exp_qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
